// File: rtl/riscv_pkg.sv
// Shared core types: register-file widths and the writeback queue entry layout.
package riscv_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  is_load;
    logic                  ready;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_queue_if.sv
// Issue/memory/reg-file/decode signals of the writeback queue.
// The queue takes the slave side; issue and friends take the master side.
interface reg_writeback_queue_if;
  import riscv_pkg::*;

  logic                  PUSH_VALID;
  logic [REG_ADDR_W-1:0] PUSH_RD;
  logic                  PUSH_WE;
  logic                  PUSH_LOAD;
  logic [XLEN-1:0]       PUSH_DATA;
  logic                  FULL;
  logic                  MEM_VALID;
  logic [XLEN-1:0]       MEM_DATA;
  logic                  LOAD_PENDING;
  logic                  MEM_ERR;
  logic                  WRITE;
  logic [REG_ADDR_W-1:0] INADDRESS;
  logic [XLEN-1:0]       IN;
  logic                  InstHIT;
  logic [REG_ADDR_W-1:0] LOOKUP_ADDR;
  logic                  LOOKUP_HIT;
  logic                  LOOKUP_RDY;
  logic [XLEN-1:0]       LOOKUP_DATA;

  modport master (
    output PUSH_VALID, PUSH_RD, PUSH_WE, PUSH_LOAD, PUSH_DATA, MEM_VALID, MEM_DATA, LOOKUP_ADDR,
    input  FULL, LOAD_PENDING, MEM_ERR, WRITE, INADDRESS, IN, InstHIT,
           LOOKUP_HIT, LOOKUP_RDY, LOOKUP_DATA
  );

  modport slave (
    input  PUSH_VALID, PUSH_RD, PUSH_WE, PUSH_LOAD, PUSH_DATA, MEM_VALID, MEM_DATA, LOOKUP_ADDR,
    output FULL, LOAD_PENDING, MEM_ERR, WRITE, INADDRESS, IN, InstHIT,
           LOOKUP_HIT, LOOKUP_RDY, LOOKUP_DATA
  );

endinterface

// File: rtl/wb_fwd_lookup.sv
// Forwarding search: youngest valid writing entry whose rd matches the query.
module wb_fwd_lookup
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  wb_entry_t                    entries_i [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]     head_i,
  input  logic [REG_ADDR_W-1:0]        addr_i,
  output logic                         hit_o,
  output logic                         rdy_o,
  output logic [XLEN-1:0]              data_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0] idx;

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    hit_o  = 1'b0;
    rdy_o  = 1'b0;
    data_o = '0;
    idx    = head_i;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_i + PtrW'(i);
      if (addr_i != '0 && entries_i[idx].valid && entries_i[idx].we &&
          entries_i[idx].rd == addr_i) begin
        hit_o  = 1'b1;
        rdy_o  = entries_i[idx].ready;
        data_o = entries_i[idx].ready ? entries_i[idx].data : '0;
      end
    end
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// In-order writeback queue draining ALU and load results into the register file,
// with a forwarding lookup for decode.
module reg_writeback_queue
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  reg_writeback_queue_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [PtrW-1:0] ptr_t;

  wb_entry_t       entries_q [DEPTH];
  wb_entry_t       entries_d [DEPTH];
  ptr_t            head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            mem_err_q, mem_err_d;

  wb_entry_t head_e;
  logic      full, push_en, pop_en, fill_found;
  ptr_t      fill_ptr, scan_idx;

  assign head_e  = entries_q[head_q];
  assign full    = (count_q == CntW'(DEPTH));
  assign pop_en  = head_e.valid & head_e.ready;
  assign push_en = bus.PUSH_VALID & ~full;

  // Fill target is the oldest stored load still waiting for data.
  always_comb begin
    fill_found = 1'b0;
    fill_ptr   = head_q;
    scan_idx   = head_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + ptr_t'(i);
      if (!fill_found && entries_q[scan_idx].valid && entries_q[scan_idx].is_load &&
          !entries_q[scan_idx].ready) begin
        fill_found = 1'b1;
        fill_ptr   = scan_idx;
      end
    end
  end

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    mem_err_d = mem_err_q;

    if (pop_en) begin
      entries_d[head_q].valid = 1'b0;
      head_d                  = head_q + ptr_t'(1);
    end

    if (bus.MEM_VALID) begin
      if (fill_found) begin
        entries_d[fill_ptr].ready = 1'b1;
        entries_d[fill_ptr].data  = bus.MEM_DATA;
      end else begin
        mem_err_d = 1'b1;
      end
    end

    if (push_en) begin
      entries_d[tail_q].valid   = 1'b1;
      entries_d[tail_q].rd      = bus.PUSH_RD;
      entries_d[tail_q].we      = bus.PUSH_WE & (bus.PUSH_RD != '0);
      entries_d[tail_q].is_load = bus.PUSH_LOAD;
      entries_d[tail_q].ready   = ~bus.PUSH_LOAD;
      entries_d[tail_q].data    = bus.PUSH_LOAD ? '0 : bus.PUSH_DATA;
      tail_d                    = tail_q + ptr_t'(1);
    end

    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      mem_err_q <= 1'b0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Write port is driven straight from head storage; the reg file samples as the head pops.
  assign bus.FULL         = full;
  assign bus.LOAD_PENDING = fill_found;
  assign bus.MEM_ERR      = mem_err_q;
  assign bus.InstHIT      = pop_en;
  assign bus.WRITE        = pop_en & head_e.we;
  assign bus.INADDRESS    = pop_en ? head_e.rd : '0;
  assign bus.IN           = pop_en ? head_e.data : '0;

  wb_fwd_lookup #(
    .DEPTH (DEPTH)
  ) u_fwd_lookup (
    .entries_i (entries_q),
    .head_i    (head_q),
    .addr_i    (bus.LOOKUP_ADDR),
    .hit_o     (bus.LOOKUP_HIT),
    .rdy_o     (bus.LOOKUP_RDY),
    .data_o    (bus.LOOKUP_DATA)
  );

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Scoreboard bench: expected reg-file writes are queued at push time and popped on InstHIT.
module tb_reg_writeback_queue;

  logic CLK;
  logic RESET;

  reg_writeback_queue_if bus ();

  reg_writeback_queue #(
    .DEPTH (4)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_alu(input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    bus.PUSH_VALID = 1'b1;
    bus.PUSH_RD    = rd;
    bus.PUSH_WE    = 1'b1;
    bus.PUSH_LOAD  = 1'b0;
    bus.PUSH_DATA  = data;
    e.rd = rd; e.we = (rd != 5'd0); e.data = data;
    exp_q.push_back(e);
    tick();
    bus.PUSH_VALID = 1'b0;
  endtask

  task automatic push_load(input logic [4:0] rd, input logic [31:0] fut);
    exp_t e;
    bus.PUSH_VALID = 1'b1;
    bus.PUSH_RD    = rd;
    bus.PUSH_WE    = 1'b1;
    bus.PUSH_LOAD  = 1'b1;
    bus.PUSH_DATA  = 32'hDEAD_0000;
    e.rd = rd; e.we = (rd != 5'd0); e.data = fut;
    exp_q.push_back(e);
    mem_q.push_back(fut);
    tick();
    bus.PUSH_VALID = 1'b0;
    bus.PUSH_LOAD  = 1'b0;
  endtask

  task automatic mem_resp();
    bus.MEM_VALID = 1'b1;
    bus.MEM_DATA  = (mem_q.size() != 0) ? mem_q.pop_front() : 32'hE0E0_E0E0;
    tick();
    bus.MEM_VALID = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = budget;
    while (exp_q.size() != 0 && n > 0) begin
      tick();
      n--;
    end
    check_eq("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  // Every retirement must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (RESET) begin
      if (bus.InstHIT) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_write", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("wb_addr", 64'(bus.INADDRESS), 64'(e.rd));
          check_eq("wb_we", 64'(bus.WRITE), 64'(e.we));
          check_eq("wb_data", 64'(bus.IN), 64'(e.data));
        end
      end else begin
        check_eq("idle_port", {31'd0, bus.WRITE, 27'd0, bus.INADDRESS}, 64'd0);
        check_eq("idle_data", 64'(bus.IN), 64'd0);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctl"}, {57'd0, bus.WRITE, bus.InstHIT, bus.FULL, bus.LOAD_PENDING,
                             bus.MEM_ERR, bus.LOOKUP_HIT, bus.LOOKUP_RDY}, 64'd0);
    check_eq({tag, "_addr"}, 64'(bus.INADDRESS), 64'd0);
    check_eq({tag, "_in"}, 64'(bus.IN), 64'd0);
    check_eq({tag, "_ldata"}, 64'(bus.LOOKUP_DATA), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET          = 1'b0;
    bus.PUSH_VALID = 1'b0;
    bus.PUSH_RD    = '0;
    bus.PUSH_WE    = 1'b0;
    bus.PUSH_LOAD  = 1'b0;
    bus.PUSH_DATA  = '0;
    bus.MEM_VALID  = 1'b0;
    bus.MEM_DATA   = '0;
    bus.LOOKUP_ADDR = '0;
    #1;
    check_all_zero("reset_state");
    #11;
    RESET = 1'b1;
    tick();

    // Mid-run reset with three entries held behind an unready load.
    push_load(5'd1, 32'h1111);
    push_alu(5'd2, 32'h22);
    push_alu(5'd3, 32'h33);
    bus.LOOKUP_ADDR = 5'd2;
    #1;
    check_eq("pre_rst_hit", {62'd0, bus.LOOKUP_HIT, bus.LOOKUP_RDY}, 64'd3);
    check_eq("pre_rst_ldata", 64'(bus.LOOKUP_DATA), 64'h22);
    RESET = 1'b0;
    #1;
    check_all_zero("async_rst");
    exp_q.delete();
    mem_q.delete();
    #4;
    RESET = 1'b1;
    bus.LOOKUP_ADDR = '0;
    repeat (3) tick();
    check_eq("post_rst_pending", 64'(bus.LOAD_PENDING), 64'd0);

    // Single ALU write retires one edge after the push, for one cycle only.
    push_alu(5'd5, 32'h0000_00AA);
    @(negedge CLK);
    check_eq("alu_hit", 64'(bus.InstHIT), 64'd1);
    tick();
    @(negedge CLK);
    check_eq("alu_hit_once", 64'(bus.InstHIT), 64'd0);
    tick();

    // Load at head blocks a younger ready ALU result until filled.
    push_load(5'd3, 32'h0000_1234);
    push_alu(5'd4, 32'd7);
    @(negedge CLK);
    check_eq("ld_pending", 64'(bus.LOAD_PENDING), 64'd1);
    tick();
    mem_resp();
    drain(10);

    // Full queue with unready head: held push is refused until the pop frees a slot.
    push_load(5'd10, 32'h0000_BEEF);
    push_alu(5'd11, 32'h11);
    push_alu(5'd12, 32'h12);
    push_alu(5'd13, 32'h13);
    @(negedge CLK);
    check_eq("full_set", 64'(bus.FULL), 64'd1);
    bus.LOOKUP_ADDR = 5'd14;
    begin
      exp_t e;
      e.rd = 5'd14; e.we = 1'b1; e.data = 32'h55;
      exp_q.push_back(e);
    end
    tick();
    bus.PUSH_VALID = 1'b1;
    bus.PUSH_RD    = 5'd14;
    bus.PUSH_WE    = 1'b1;
    bus.PUSH_LOAD  = 1'b0;
    bus.PUSH_DATA  = 32'h55;
    repeat (2) begin
      tick();
      @(negedge CLK);
      check_eq("full_hold", 64'(bus.FULL), 64'd1);
      check_eq("full_ignored", 64'(bus.LOOKUP_HIT), 64'd0);
    end
    tick();
    bus.MEM_VALID = 1'b1;
    bus.MEM_DATA  = mem_q.pop_front();
    tick();
    bus.MEM_VALID = 1'b0;
    @(negedge CLK);
    check_eq("full_at_fill", 64'(bus.FULL), 64'd1);
    tick();
    @(negedge CLK);
    check_eq("full_dropped", 64'(bus.FULL), 64'd0);
    check_eq("push_not_yet", 64'(bus.LOOKUP_HIT), 64'd0);
    tick();
    bus.PUSH_VALID = 1'b0;
    @(negedge CLK);
    check_eq("held_push_hit", {62'd0, bus.LOOKUP_HIT, bus.LOOKUP_RDY}, 64'd3);
    check_eq("held_push_data", 64'(bus.LOOKUP_DATA), 64'h55);
    drain(12);

    // x0 destination retires without a write and never forwards.
    push_alu(5'd0, 32'hFF);
    bus.LOOKUP_ADDR = 5'd0;
    @(negedge CLK);
    check_eq("x0_hit", 64'(bus.InstHIT), 64'd1);
    check_eq("x0_lookup", 64'(bus.LOOKUP_HIT), 64'd0);
    drain(4);

    // Youngest match wins: an unready load to x9 shadows an older ready x9.
    push_load(5'd20, 32'h0000_2020);
    push_alu(5'd9, 32'd1);
    push_load(5'd9, 32'h0000_9999);
    bus.LOOKUP_ADDR = 5'd9;
    @(negedge CLK);
    check_eq("fwd_young_hit", {62'd0, bus.LOOKUP_HIT, bus.LOOKUP_RDY}, 64'd2);
    check_eq("fwd_young_data", 64'(bus.LOOKUP_DATA), 64'd0);
    bus.LOOKUP_ADDR = 5'd20;
    #1;
    check_eq("fwd_ld20", {62'd0, bus.LOOKUP_HIT, bus.LOOKUP_RDY}, 64'd2);
    tick();
    mem_resp();
    mem_resp();
    drain(10);
    check_eq("mem_err_clear", 64'(bus.MEM_ERR), 64'd0);

    // Stray memory response sets a sticky error and writes nothing.
    bus.MEM_VALID = 1'b1;
    bus.MEM_DATA  = 32'h77;
    tick();
    bus.MEM_VALID = 1'b0;
    @(negedge CLK);
    check_eq("mem_err_set", 64'(bus.MEM_ERR), 64'd1);
    repeat (3) tick();
    check_eq("mem_err_sticky", 64'(bus.MEM_ERR), 64'd1);
    check_eq("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
